perf_counter_bank: RTL and testbench

Synthesizable per-event performance counter bank for the pipelined core, generalising the bench-only instruction/cache-hit tallies into RTL. Counts `NUM_EVT` single-bit event strobes (retire, I/D-cache request, I/D-cache hit, …) plus a cycle counter, all `CNT_W` wide. A run-control state machine starts counting, freezes all counts on halt and clears them. A registered read port lets software or the bench pull any counter while the core is running or after it has stopped.

---
 rtl/perf_counter_bank_if.sv | 29 ++
 rtl/perf_counter_bank.sv | 120 ++++++++++++
 tb/tb_perf_counter_bank.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Read-port bus of the performance counter bank.
// The master issues rd_req/rd_idx; the slave (the counter bank) returns
// rd_valid/rd_data/rd_ovf exactly one cycle later.
interface perf_counter_bank_if #(
    parameter int CNT_W = 32,
    parameter int IDX_W = 4
) ();
    logic             rd_req;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;

    modport master (
        output rd_req,
        output rd_idx,
        input  rd_valid,
        input  rd_data,
        input  rd_ovf
    );

    modport slave (
        input  rd_req,
        input  rd_idx,
        output rd_valid,
        output rd_data,
        output rd_ovf
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Performance counter bank: NUM_EVT event counters plus one cycle counter,
// gated by a small run-control FSM (IDLE / RUN / FROZEN) and read through a
// registered one-cycle-latency port.
// Optional build macro PERF_SAT_EN: counters saturate at all-ones instead of
// wrapping to zero. Either way the sticky ovf bit sets on that increment.
module perf_counter_bank #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 clear,
    input  logic [NUM_EVT-1:0]   evt,
    perf_counter_bank_if.slave   rd,
    output logic [1:0]           state,
    output logic [NUM_EVT:0]     ovf
);

    // Counter slot NUM_EVT is the cycle counter; slots below are events.
    localparam int NUM_CNT = NUM_EVT + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   sel_data;
    logic               sel_ovf;

    // Increment requests: only while in RUN, and a clear in the same cycle
    // drops them. The cycle counter's request is always set in RUN.
    assign inc = (state_q == RUN && !clear) ? {1'b1, evt} : '0;

    assign state = state_q;

    // Run-control FSM; clear beats halt, halt beats start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && !halt) state_q <= RUN;
                RUN:     if (halt)           state_q <= FROZEN;
                FROZEN:  if (start && !halt) state_q <= RUN;
                default:                     state_q <= IDLE;
            endcase
        end
    end

    // Counters and sticky overflow flags; an increment at all-ones flags
    // overflow and either wraps or holds depending on the build.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc[i]) begin
                    if (cnt[i] == '1) begin
                        ovf[i] <= 1'b1;
`ifdef PERF_SAT_EN
                        cnt[i] <= cnt[i];
`else
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read mux: indices beyond the cycle counter fall through to zero.
    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd.rd_idx == IDX_W'(i)) begin
                sel_data = cnt[i];
                sel_ovf  = ovf[i];
            end
        end
    end

    // Registered read response, one result per requested cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_ovf   <= 1'b0;
        end else begin
            rd.rd_valid <= rd.rd_req;
            if (rd.rd_req) begin
                rd.rd_data <= sel_data;
                rd.rd_ovf  <= sel_ovf;
            end else begin
                rd.rd_data <= '0;
                rd.rd_ovf  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (NUM_EVT=6, CNT_W=4) with a
// behavioural integer model of counts, overflow flags and run state.
module tb_perf_counter_bank;

    localparam int NUM_EVT = 6;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 4;
    localparam int NUM_CNT = NUM_EVT + 1;
    localparam int MAXV    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               halt;
    logic               clear;
    logic [NUM_EVT-1:0] evt;
    logic [1:0]         state;
    logic [NUM_EVT:0]   ovf;

    perf_counter_bank_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) rd_bus ();

    perf_counter_bank #(
        .NUM_EVT(NUM_EVT),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .halt (halt),
        .clear(clear),
        .evt  (evt),
        .rd   (rd_bus),
        .state(state),
        .ovf  (ovf)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fails  = 0;

    int               m_cnt [NUM_CNT];
    logic [NUM_EVT:0] m_ovf;
    int               m_state;
    logic             exp_valid;
    logic [CNT_W-1:0] exp_data;
    logic             exp_ovf;

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 0;
        m_ovf = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and
    // return #1 after the edge with the expected read response latched.
    task automatic cycle(input bit st, input bit hl, input bit cl,
                         input logic [NUM_EVT-1:0] e, input bit rq, input int ix);
        @(negedge clk);
        start = st; halt = hl; clear = cl; evt = e;
        rd_bus.rd_req = rq;
        rd_bus.rd_idx = ix[IDX_W-1:0];
        @(posedge clk);
        exp_valid = rq;
        if (rq && ix <= NUM_EVT) begin
            exp_data = m_cnt[ix][CNT_W-1:0];
            exp_ovf  = m_ovf[ix];
        end else begin
            exp_data = '0;
            exp_ovf  = 1'b0;
        end
        if (cl) begin
            for (int i = 0; i < NUM_CNT; i++) m_cnt[i] = 0;
            m_ovf = '0;
        end else if (m_state == 1) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (i == NUM_EVT || e[i]) begin
                    if (m_cnt[i] + 1 > MAXV) begin
                        m_ovf[i] = 1'b1;
`ifdef PERF_SAT_EN
                        m_cnt[i] = MAXV;
`else
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
`endif
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        if (cl)                                 m_state = 0;
        else if (m_state == 1 && hl)            m_state = 2;
        else if (m_state != 1 && st && !hl)     m_state = 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; halt = 0; clear = 0; evt = '0;
        rd_bus.rd_req = 1'b0; rd_bus.rd_idx = '0;
        model_reset();
        #12;
        n_checks++; if (state !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_state got=%b want=00", state); end
        n_checks++; if (ovf !== '0) begin n_fails++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
        n_checks++; if (rd_bus.rd_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_bus.rd_valid); end
        n_checks++; if (rd_bus.rd_data !== '0) begin n_fails++; $display("[TB] FAIL reset_rd_data got=%0d want=0", rd_bus.rd_data); end
        n_checks++; if (rd_bus.rd_ovf !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rd_ovf got=%b want=0", rd_bus.rd_ovf); end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < NUM_CNT; k++) begin
            cycle(0, 0, 0, '0, 1, k);
            n_checks++; if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== '0) begin n_fails++; $display("[TB] FAIL reset_read idx=%0d got=%b/%0d want=1/0", k, rd_bus.rd_valid, rd_bus.rd_data); end
        end
    endtask

    task automatic test_count_halt();
        logic [CNT_W-1:0] want [3];
        int               idx  [3];
        want = '{4'd11, 4'd11, 4'd11};
        idx  = '{0, 1, 6};
        cycle(1, 0, 0, '0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(0, 0, 0, 6'b000011, 0, 0);
        cycle(0, 1, 0, 6'b000011, 0, 0);
        n_checks++; if (state !== 2'b10) begin n_fails++; $display("[TB] FAIL halt_state got=%b want=10", state); end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, '0, 1, idx[k]);
            n_checks++; if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== want[k]) begin n_fails++; $display("[TB] FAIL halt_count idx=%0d got=%b/%0d want=1/%0d", idx[k], rd_bus.rd_valid, rd_bus.rd_data, want[k]); end
        end
    endtask

    task automatic test_frozen_reads();
        logic [CNT_W-1:0] frozen_ref [NUM_CNT];
        frozen_ref = '{4'd11, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd11};
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, NUM_EVT'($urandom), 1, k % NUM_CNT);
            n_checks++; if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== frozen_ref[k % NUM_CNT]) begin n_fails++; $display("[TB] FAIL frozen_read idx=%0d got=%b/%0d want=1/%0d", k % NUM_CNT, rd_bus.rd_valid, rd_bus.rd_data, frozen_ref[k % NUM_CNT]); end
        end
        n_checks++; if (state !== 2'b10) begin n_fails++; $display("[TB] FAIL frozen_state got=%b want=10", state); end
    endtask

    task automatic test_bad_index();
        int bad [3];
        bad = '{9, 15, 7};
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, '0, 1, bad[k]);
            n_checks++; if (rd_bus.rd_valid !== 1'b1 || rd_bus.rd_data !== '0 || rd_bus.rd_ovf !== 1'b0) begin n_fails++; $display("[TB] FAIL bad_index idx=%0d got=%b/%0d/%b want=1/0/0", bad[k], rd_bus.rd_valid, rd_bus.rd_data, rd_bus.rd_ovf); end
        end
    endtask

    task automatic test_overflow();
        logic [CNT_W-1:0] want2;
`ifdef PERF_SAT_EN
        want2 = 4'd15;
`else
        want2 = 4'd0;
`endif
        cycle(0, 0, 1, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);
        for (int k = 0; k < 16; k++) cycle(0, 0, 0, 6'b000100, 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        cycle(0, 0, 0, '0, 1, 2);
        n_checks++; if (rd_bus.rd_data !== want2 || rd_bus.rd_ovf !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_idx2 got=%0d/%b want=%0d/1", rd_bus.rd_data, rd_bus.rd_ovf, want2); end
        n_checks++; if (ovf !== 7'b1000100) begin n_fails++; $display("[TB] FAIL ovf_flags got=%b want=1000100", ovf); end
    endtask

    task automatic test_clear_priority();
        cycle(1, 0, 0, '0, 0, 0);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, '1, 0, 0);
        cycle(1, 1, 1, '1, 0, 0);
        n_checks++; if (state !== 2'b00) begin n_fails++; $display("[TB] FAIL clear_state got=%b want=00", state); end
        n_checks++; if (ovf !== '0) begin n_fails++; $display("[TB] FAIL clear_ovf got=%b want=0", ovf); end
        for (int k = 0; k < NUM_CNT; k++) begin
            cycle(0, 0, 0, '1, 1, k);
            n_checks++; if (rd_bus.rd_data !== '0 || rd_bus.rd_ovf !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_read idx=%0d got=%0d/%b want=0/0", k, rd_bus.rd_data, rd_bus.rd_ovf); end
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0, '0, 0, 0);
        for (int k = 0; k < 17; k++) cycle(0, 0, 0, '1, 1, k % NUM_CNT);
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (state !== 2'b00) begin n_fails++; $display("[TB] FAIL async_state got=%b want=00", state); end
        n_checks++; if (ovf !== '0) begin n_fails++; $display("[TB] FAIL async_ovf got=%b want=0", ovf); end
        n_checks++; if (rd_bus.rd_valid !== 1'b0 || rd_bus.rd_data !== '0 || rd_bus.rd_ovf !== 1'b0) begin n_fails++; $display("[TB] FAIL async_rd got=%b/%0d/%b want=0/0/0", rd_bus.rd_valid, rd_bus.rd_data, rd_bus.rd_ovf); end
        #1 rst = 1'b1;
        cycle(1, 0, 0, '0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 6'b000001, 0, 0);
        cycle(0, 1, 0, 6'b000001, 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        n_checks++; if (rd_bus.rd_data !== 4'd4) begin n_fails++; $display("[TB] FAIL async_restart_idx0 got=%0d want=4", rd_bus.rd_data); end
        cycle(0, 0, 0, '0, 1, NUM_EVT);
        n_checks++; if (rd_bus.rd_data !== 4'd4) begin n_fails++; $display("[TB] FAIL async_restart_cycles got=%0d want=4", rd_bus.rd_data); end
    endtask

    task automatic test_random();
        bit cl, hl, st, rq;
        cycle(0, 0, 1, '0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            cl = ($urandom_range(0, 49) == 0);
            hl = ($urandom_range(0, 14) == 0);
            st = !hl && ($urandom_range(0, 5) == 0);
            rq = ($urandom_range(0, 3) != 0);
            cycle(st, hl, cl, NUM_EVT'($urandom), rq, $urandom_range(0, 15));
            n_checks++; if (state !== 2'(m_state)) begin n_fails++; $display("[TB] FAIL rand_state cyc=%0d got=%b want=%0d", k, state, m_state); end
            n_checks++; if (ovf !== m_ovf) begin n_fails++; $display("[TB] FAIL rand_ovf cyc=%0d got=%b want=%b", k, ovf, m_ovf); end
            n_checks++; if (rd_bus.rd_valid !== exp_valid) begin n_fails++; $display("[TB] FAIL rand_valid cyc=%0d got=%b want=%b", k, rd_bus.rd_valid, exp_valid); end
            if (rq) begin
                n_checks++; if (rd_bus.rd_data !== exp_data || rd_bus.rd_ovf !== exp_ovf) begin n_fails++; $display("[TB] FAIL rand_read cyc=%0d got=%0d/%b want=%0d/%b", k, rd_bus.rd_data, rd_bus.rd_ovf, exp_data, exp_ovf); end
            end
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_count_halt();
        test_frozen_reads();
        test_bad_index();
        test_overflow();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
